// File: rtl/nibble_serial_cmp.sv
// Nibble-serial unsigned magnitude comparator, MSB nibble first, registered L/E/G result.
// Optional build macro NIBBLE_CMP_EARLY_EXIT_EN finishes as soon as the result is decided.
module nibble_serial_cmp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Handshake: start is taken on any edge where the block is IDLE (busy low);
    // done pulses for one cycle and lt/eq/gt are valid from then until the next done.
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        acc_q, acc_d;
    logic [2:0]        res_q, res_d;
    logic              done_q, done_d;

    logic [3:0]        n_a;
    logic [3:0]        n_b;
    logic [2:0]        step;
    logic              finish;

    // Operands shift left each step so the nibble under test is always on top.
    assign n_a  = a_q[WIDTH-1 -: 4];
    assign n_b  = b_q[WIDTH-1 -: 4];
    assign step = acc_q[1] ? {n_a < n_b, n_a == n_b, n_a > n_b} : acc_q;

`ifdef NIBBLE_CMP_EARLY_EXIT_EN
    assign finish = (idx_q == '0) || (acc_q[1] && (n_a != n_b));
`else
    assign finish = (idx_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDXW'(NIBBLES - 1);
                    acc_d   = 3'b010;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q << 4;
                b_d   = b_q << 4;
                acc_d = step;
                idx_d = idx_q - IDXW'(1);
                if (finish) begin
                    res_d   = step;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign lt   = res_q[2];
    assign eq   = res_q[1];
    assign gt   = res_q[0];

endmodule
